// File: rtl/div_mod.sv
// Multi-cycle 20/8 restoring divider with optional signed mode and registered operands.
// IDLE accepts a request, RUN produces one quotient bit per cycle, FIX applies signs, DONE presents the result.
module div_mod #(
  parameter int NoConfigBits = 2
) (
  input  logic                    UserCLK,
  input  logic                    rst,
  input  logic [19:0]             A,
  input  logic [7:0]              B,
  input  logic                    start,
  input  logic                    clr,
  output logic [19:0]             Q,
  output logic [7:0]              R,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] a_op_q, a_op_d, dvd_q, dvd_d, q_q, q_d;
  logic [7:0]  b_op_q, b_op_d, dsr_q, dsr_d, rem_q, rem_d, alow_q, alow_d, r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, dz_q, dz_d;

  logic [19:0] a_in, a_mag;
  logic [7:0]  b_in, b_mag;
  logic        a_neg, b_neg;
  logic [8:0]  sh;
  logic [9:0]  diff;

  // Operand source: live pins, or the copy captured on the previous edge.
  always_comb begin
    a_in  = ConfigBits[1] ? a_op_q : A;
    b_in  = ConfigBits[1] ? b_op_q : B;
    a_neg = ConfigBits[0] & a_in[19];
    b_neg = ConfigBits[0] & b_in[7];
    a_mag = a_neg ? -a_in : a_in;
    b_mag = b_neg ? -b_in : b_in;
    sh    = {rem_q, dvd_q[19]};
    diff  = {1'b0, sh} - {2'b00, dsr_q};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (zero_q) state_d = DONE;
               else if (cnt_q == 5'd19) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    a_op_d = A;
    b_op_d = B;
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    alow_d = alow_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d  = a_mag;
        rem_d  = 8'd0;
        dsr_d  = b_mag;
        cnt_d  = 5'd0;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        zero_d = (b_in == 8'd0);
        alow_d = a_in[7:0];
      end
      RUN: if (zero_q) begin
        q_d  = 20'hFFFFF;
        r_d  = alow_q;
        dz_d = 1'b1;
      end else begin
        // Restoring step: remainder never exceeds the divisor, so 8 bits suffice.
        rem_d = diff[9] ? sh[7:0] : diff[7:0];
        dvd_d = {dvd_q[18:0], ~diff[9]};
        cnt_d = cnt_q + 5'd1;
      end
      FIX: begin
        q_d  = qneg_q ? -dvd_q : dvd_q;
        r_d  = rneg_q ? -rem_q : rem_q;
        dz_d = 1'b0;
      end
      default: ;
    endcase
    if (clr) begin
      q_d  = q_q;
      r_d  = r_q;
      dz_d = dz_q;
    end
  end

  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_op_q  <= '0;
      b_op_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      alow_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      alow_q  <= alow_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == FIX);
    done = (state_q == DONE);
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;

endmodule

// File: doc/div_mod.md
DIV_MOD -- requirements
Module: div_mod

Interface
REQ-001 The block SHALL have parameter NoConfigBits, default 2, meaning the width of the ConfigBits port.
REQ-002 The block SHALL have port UserCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port A, input, 20 bits: dividend.
REQ-005 The block SHALL have port B, input, 8 bits: divisor.
REQ-006 The block SHALL have port start, input, 1 bit: request to divide; sampled only in IDLE.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous abort.
REQ-008 The block SHALL have port Q, output, 20 bits: quotient.
REQ-009 The block SHALL have port R, output, 8 bits: remainder.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last result came from a zero divisor.
REQ-013 The block SHALL have port ConfigBits, input, NoConfigBits bits: bit 0 selects signed mode (1 = two's complement); bit 1 selects registered operands (1 = A/B captured into operand registers on every edge and the registered copies used at the accepting edge; 0 = live A/B used).
REQ-014 UserCLK SHALL be an external shared port, and ConfigBits SHALL be a global port placed after all switch-matrix pins.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FIX, DONE.
- IDLE + start=1 -> RUN (accepting edge, edge 0): operands latched, iteration count = 0.
- RUN: one restoring-division quotient bit per edge, edges 1..20.
- After edge 20 -> FIX: sign correction.
- Edge 21 -> DONE: Q, R and div_zero registered.
- Edge 22 -> IDLE.
REQ-016 done SHALL be 1 only in DONE, for exactly one cycle, i.e. the cycle after edge 21.
REQ-017 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-018 start SHALL be ignored in RUN, FIX and DONE; a new operation SHALL be accepted only from IDLE, so at most one operation starts every 23 cycles.
REQ-019 Unsigned mode: Q = A / B (truncated) and R = A mod B, both as unsigned values.
REQ-020 Signed mode: the division SHALL operate on magnitudes; the quotient sign SHALL be A[19] xor B[7]; the remainder sign SHALL follow the dividend (truncation toward zero); the magnitude of R is < 128.
REQ-021 Signed overflow: -524288 / -1 SHALL yield Q = 20'h80000 (two's-complement wrap) and R = 0, with no error flag.
REQ-022 Zero divisor (at the accepting edge):
- FSM SHALL go IDLE -> DONE directly, with done in the cycle after edge 1.
- Q SHALL be 20'hFFFFF, R SHALL be A[7:0], and div_zero SHALL be 1.
REQ-023 Q, R and div_zero SHALL change only on entry to DONE and SHALL hold their values until the next DONE.
REQ-024 clr=1 at any edge SHALL force IDLE, suppress done, and leave Q, R and div_zero unchanged; clr takes priority over start.

Reset
REQ-025 When rst=1, asynchronously: state = IDLE, Q = 0, R = 0, busy = 0, done = 0, div_zero = 0, and the operand/internal registers = 0.
REQ-026 A reset mid-operation SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Verification
REQ-027 Unsigned, A=1000, B=7, pulse start -> done in the cycle after edge 21, Q=142, R=6, div_zero=0; busy high for the 21 cycles before done.
REQ-028 Signed, A=-1000 (20'hFFC18), B=7 -> Q=20'hFFF72, R=8'hFA; and unsigned A=20'hFFFFF, B=8'hFF -> Q=20'h01010, R=8'h0F.
REQ-029 A=12345, B=0 -> done in the cycle after edge 1, Q=20'hFFFFF, R=8'h39, div_zero=1; a following valid divide clears div_zero.
REQ-030 Signed, A=20'h80000, B=8'hFF -> Q=20'h80000, R=0.
REQ-031 Start pulses during RUN, FIX and DONE are ignored (exactly one done); clr at edge 10 -> no done and Q/R keep their previous values; rst asserted mid-RUN -> all outputs 0 immediately, then a new start gives the correct result.
